// File: rtl/lift_shaft_model_pkg.sv
// lift_pkg: shared definitions for the lift shaft model.
//   motion_state_e   - motion state of the cab
//   sensors_t        - active-low end-stop / middle sensor bundle
//   decode_sensors() - position -> sensor levels for a shaft of height pos_max
package lift_pkg;

  localparam int POS_MAX_DEF     = 16;
  localparam int STEP_CYCLES_DEF = 4;

  typedef enum logic [1:0] {
    ST_STOPPED = 2'd0,
    ST_UP      = 2'd1,
    ST_DOWN    = 2'd2,
    ST_FAULT   = 2'd3
  } motion_state_e;

  // All sensors are active low: 0 means the cab is in the sensed zone.
  typedef struct packed {
    logic bottom;
    logic middle_minus;
    logic middle_plus;
    logic top;
  } sensors_t;

  function automatic sensors_t decode_sensors(input int pos, input int pos_max);
    sensors_t s;
    int mid;
    mid            = pos_max / 2;
    s.bottom       = (pos == 0) ? 1'b0 : 1'b1;
    s.middle_minus = ((pos == mid - 1) || (pos == mid)) ? 1'b0 : 1'b1;
    s.middle_plus  = ((pos == mid) || (pos == mid + 1)) ? 1'b0 : 1'b1;
    s.top          = (pos == pos_max) ? 1'b0 : 1'b1;
    return s;
  endfunction

endpackage

// File: rtl/lift_shaft_model_if.sv
// lift_shaft_model_if: motor command and cab feedback bundle.
//   direction, enable (motor command, enable active low)
//   bottom, middle_minus, middle_plus, top (active-low sensors)
//   position, moving, overrun (cab status)
// master drives the motor command, slave (the shaft model) returns status.
interface lift_shaft_model_if #(
  parameter int POS_W = 5
);
  logic             direction;
  logic             enable;
  logic             bottom;
  logic             middle_minus;
  logic             middle_plus;
  logic             top;
  logic [POS_W-1:0] position;
  logic             moving;
  logic             overrun;

  modport master (
    output direction, enable,
    input  bottom, middle_minus, middle_plus, top, position, moving, overrun
  );

  modport slave (
    input  direction, enable,
    output bottom, middle_minus, middle_plus, top, position, moving, overrun
  );
endinterface

// File: rtl/lift_shaft_model_prescaler.sv
// step_prescaler: counts 0..STEP_CYCLES-1 while run is high.
//   clock, n_reset - clock and async active-low reset
//   clear          - force the count back to 0 (takes priority over run)
//   run            - advance the count
//   tc             - high in the cycle the count is at its last value and
//                    run is set; the count wraps to 0 on that edge
module step_prescaler #(
  parameter int STEP_CYCLES = 4
) (
  input  logic clock,
  input  logic n_reset,
  input  logic clear,
  input  logic run,
  output logic tc
);
  localparam int CNT_W = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(STEP_CYCLES - 1);

  logic [CNT_W-1:0] count_r;
  logic [CNT_W-1:0] count_next_s;

  assign tc = run & ~clear & (count_r == LAST);

  // Next count: cleared, wrapped, advanced, or parked at zero when idle.
  always_comb begin
    count_next_s = count_r;
    if (clear || !run) begin
      count_next_s = {CNT_W{1'b0}};
    end else if (count_r == LAST) begin
      count_next_s = {CNT_W{1'b0}};
    end else begin
      count_next_s = count_r + CNT_W'(1);
    end
  end

  // Count register.
  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      count_r <= {CNT_W{1'b0}};
    end else begin
      count_r <= count_next_s;
    end
  end
endmodule

// File: rtl/lift_shaft_model.sv
// lift_shaft_model: behavioural model of a lift cab in a shaft.
//   clock, n_reset - clock and async active-low reset
//   bus (slave)    - direction/enable in; sensors, position, moving,
//                    overrun out (all registered)
// The cab moves one position every STEP_CYCLES clocks while enable is low.
// Running into an end stop latches FAULT until reset.
module lift_shaft_model
  import lift_pkg::*;
#(
  parameter int POS_MAX     = POS_MAX_DEF,
  parameter int STEP_CYCLES = STEP_CYCLES_DEF,
  parameter int RESET_POS   = 0
) (
  input  logic              clock,
  input  logic              n_reset,
  lift_shaft_model_if.slave bus
);
  localparam int POS_W = $clog2(POS_MAX + 1);
  localparam logic [POS_W-1:0] POS_TOP = POS_W'(POS_MAX);

  motion_state_e    state_r;
  motion_state_e    state_next_s;
  logic [POS_W-1:0] pos_r;
  logic [POS_W-1:0] pos_next_s;
  sensors_t         sens_r;
  logic             moving_r;
  logic             overrun_r;
  logic             presc_clear_s;
  logic             presc_run_s;
  logic             presc_tc_s;

  assign presc_run_s = (state_r == ST_UP) || (state_r == ST_DOWN);

  step_prescaler #(.STEP_CYCLES(STEP_CYCLES)) u_prescaler (
    .clock  (clock),
    .n_reset(n_reset),
    .clear  (presc_clear_s),
    .run    (presc_run_s),
    .tc     (presc_tc_s)
  );

  // Next state and next position; every state change restarts the prescaler.
  always_comb begin
    state_next_s  = state_r;
    pos_next_s    = pos_r;
    presc_clear_s = 1'b0;
    case (state_r)
      ST_STOPPED: begin
        if (!bus.enable) begin
          state_next_s  = bus.direction ? ST_UP : ST_DOWN;
          presc_clear_s = 1'b1;
        end else begin
          state_next_s = ST_STOPPED;
        end
      end
      ST_UP: begin
        if (bus.enable) begin
          state_next_s  = ST_STOPPED;
          presc_clear_s = 1'b1;
        end else if (!bus.direction) begin
          state_next_s  = ST_DOWN;
          presc_clear_s = 1'b1;
        end else if (presc_tc_s) begin
          if (pos_r == POS_TOP) begin
            state_next_s = ST_FAULT;
          end else begin
            pos_next_s = pos_r + POS_W'(1);
          end
        end else begin
          state_next_s = ST_UP;
        end
      end
      ST_DOWN: begin
        if (bus.enable) begin
          state_next_s  = ST_STOPPED;
          presc_clear_s = 1'b1;
        end else if (bus.direction) begin
          state_next_s  = ST_UP;
          presc_clear_s = 1'b1;
        end else if (presc_tc_s) begin
          if (pos_r == {POS_W{1'b0}}) begin
            state_next_s = ST_FAULT;
          end else begin
            pos_next_s = pos_r - POS_W'(1);
          end
        end else begin
          state_next_s = ST_DOWN;
        end
      end
      ST_FAULT: begin
        state_next_s = ST_FAULT;
      end
      default: begin
        state_next_s = ST_FAULT;
      end
    endcase
  end

  // State, position and outputs; sensors decode the next position so they
  // change on the same edge as position.
  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      state_r   <= ST_STOPPED;
      pos_r     <= POS_W'(RESET_POS);
      sens_r    <= decode_sensors(RESET_POS, POS_MAX);
      moving_r  <= 1'b0;
      overrun_r <= 1'b0;
    end else begin
      state_r   <= state_next_s;
      pos_r     <= pos_next_s;
      sens_r    <= decode_sensors(int'(32'(pos_next_s)), POS_MAX);
      moving_r  <= (state_next_s == ST_UP) || (state_next_s == ST_DOWN);
      overrun_r <= (state_next_s == ST_FAULT);
    end
  end

  assign bus.position     = pos_r;
  assign bus.bottom       = sens_r.bottom;
  assign bus.middle_minus = sens_r.middle_minus;
  assign bus.middle_plus  = sens_r.middle_plus;
  assign bus.top          = sens_r.top;
  assign bus.moving       = moving_r;
  assign bus.overrun      = overrun_r;
endmodule

// File: tb/tb_lift_shaft_model.sv
// Testbench for lift_shaft_model with default parameters.
module tb_lift_shaft_model;
  localparam int POS_MAX = 16;
  localparam int STEP    = 4;
  localparam int MID     = POS_MAX / 2;
  localparam int POS_W   = 5;

  logic clock;
  logic n_reset;
  int   checks;
  int   errors;

  // Reference model state: position, travel direction (+1/-1/0),
  // edges since the current run segment began, and latched fault.
  int m_pos;
  int m_dir;
  int m_since;
  bit m_fault;

  lift_shaft_model_if #(.POS_W(POS_W)) bus ();

  lift_shaft_model dut (
    .clock  (clock),
    .n_reset(n_reset),
    .bus    (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    n_reset = 1'b0;
    bus.enable = 1'b1;
    bus.direction = 1'b1;
    tick(1);
    n_reset = 1'b1;
    tick(1);
  endtask

  // Model: apply one clock edge given the inputs sampled at that edge.
  task automatic model_step(input logic en, input logic dir);
    int want;
    if (m_fault) begin
      m_dir = 0;
    end else if (m_dir == 0) begin
      if (!en) begin
        m_dir   = dir ? 1 : -1;
        m_since = 0;
      end
    end else if (en) begin
      m_dir = 0;
    end else begin
      want = dir ? 1 : -1;
      if (want != m_dir) begin
        m_dir   = want;
        m_since = 0;
      end else begin
        m_since = m_since + 1;
        if (m_since % STEP == 0) begin
          if (m_pos + m_dir < 0 || m_pos + m_dir > POS_MAX) begin
            m_fault = 1'b1;
            m_dir   = 0;
          end else begin
            m_pos = m_pos + m_dir;
          end
        end
      end
    end
  endtask

  // Compare process: advance the model on each edge, check on the falling edge.
  initial begin
    logic e, d, r;
    m_pos = 0; m_dir = 0; m_since = 0; m_fault = 1'b0;
    forever begin
      @(posedge clock);
      e = bus.enable;
      d = bus.direction;
      r = n_reset;
      @(negedge clock);
      if (!n_reset) begin
        m_pos = 0; m_dir = 0; m_since = 0; m_fault = 1'b0;
      end else if (r) begin
        model_step(e, d);
      end
      chk("position",     32'(bus.position),     32'(m_pos));
      chk("bottom",       32'(bus.bottom),       (m_pos == 0) ? 32'd0 : 32'd1);
      chk("middle_minus", 32'(bus.middle_minus), (m_pos == MID - 1 || m_pos == MID) ? 32'd0 : 32'd1);
      chk("middle_plus",  32'(bus.middle_plus),  (m_pos == MID || m_pos == MID + 1) ? 32'd0 : 32'd1);
      chk("top",          32'(bus.top),          (m_pos == POS_MAX) ? 32'd0 : 32'd1);
      chk("moving",       32'(bus.moving),       (m_dir != 0 && !m_fault) ? 32'd1 : 32'd0);
      chk("overrun",      32'(bus.overrun),      m_fault ? 32'd1 : 32'd0);
    end
  end

  // Directed stimulus with hand-computed expectations.
  initial begin
    checks = 0;
    errors = 0;
    n_reset = 1'b0;
    bus.enable = 1'b1;
    bus.direction = 1'b1;
    tick(2);
    chk("rst_bottom",  32'(bus.bottom),       32'd0);
    chk("rst_top",     32'(bus.top),          32'd1);
    chk("rst_mm",      32'(bus.middle_minus), 32'd1);
    chk("rst_mp",      32'(bus.middle_plus),  32'd1);
    chk("rst_overrun", 32'(bus.overrun),      32'd0);
    chk("rst_moving",  32'(bus.moving),       32'd0);
    chk("rst_pos",     32'(bus.position),     32'd0);
    n_reset = 1'b1;
    tick(1);

    // Run up from 0: entry edge, then 28 edges to 7, 4 more to 8.
    bus.enable = 1'b0;
    tick(1);
    chk("up_entry_pos",    32'(bus.position), 32'd0);
    chk("up_entry_moving", 32'(bus.moving),   32'd1);
    tick(28);
    chk("up7_pos", 32'(bus.position),     32'd7);
    chk("up7_mm",  32'(bus.middle_minus), 32'd0);
    chk("up7_mp",  32'(bus.middle_plus),  32'd1);
    tick(4);
    chk("up8_pos", 32'(bus.position),     32'd8);
    chk("up8_mm",  32'(bus.middle_minus), 32'd0);
    chk("up8_mp",  32'(bus.middle_plus),  32'd0);
    tick(4);
    chk("up9_mm", 32'(bus.middle_minus), 32'd1);
    chk("up9_mp", 32'(bus.middle_plus),  32'd0);

    // Stop mid-step at 5, then resume.
    do_reset();
    bus.enable = 1'b0;
    tick(21);
    tick(2);
    chk("mid_pos", 32'(bus.position), 32'd5);
    bus.enable = 1'b1;
    tick(1);
    chk("stop_moving", 32'(bus.moving), 32'd0);
    tick(3);
    chk("stop_pos", 32'(bus.position), 32'd5);
    bus.enable = 1'b0;
    tick(4);
    chk("resume_hold", 32'(bus.position), 32'd5);
    tick(1);
    chk("resume_pos", 32'(bus.position), 32'd6);

    // Reverse at 3, then run down into the bottom stop.
    do_reset();
    bus.enable = 1'b0;
    tick(13);
    chk("rev_start", 32'(bus.position), 32'd3);
    bus.direction = 1'b0;
    tick(1);
    tick(3);
    chk("rev_hold", 32'(bus.position), 32'd3);
    tick(1);
    chk("rev_pos", 32'(bus.position), 32'd2);
    tick(8);
    chk("down0_pos", 32'(bus.position), 32'd0);
    tick(4);
    chk("bot_over",   32'(bus.overrun),  32'd1);
    chk("bot_pos",    32'(bus.position), 32'd0);
    chk("bot_bottom", 32'(bus.bottom),   32'd0);

    // Overrun at the top; fault ignores inputs.
    do_reset();
    chk("clr_over", 32'(bus.overrun), 32'd0);
    bus.enable = 1'b0;
    tick(65);
    chk("top_pos", 32'(bus.position), 32'd16);
    chk("top_top", 32'(bus.top),      32'd0);
    tick(4);
    chk("ovr_over",   32'(bus.overrun),  32'd1);
    chk("ovr_top",    32'(bus.top),      32'd0);
    chk("ovr_pos",    32'(bus.position), 32'd16);
    chk("ovr_moving", 32'(bus.moving),   32'd0);
    bus.enable = 1'b1;
    tick(3);
    bus.enable = 1'b0;
    bus.direction = 1'b0;
    tick(8);
    chk("ovr_sticky", 32'(bus.overrun),  32'd1);
    chk("ovr_frozen", 32'(bus.position), 32'd16);

    // Asynchronous reset while moving at 9.
    do_reset();
    chk("clr_over2", 32'(bus.overrun), 32'd0);
    bus.enable = 1'b0;
    tick(37);
    tick(2);
    chk("pre_async_pos", 32'(bus.position), 32'd9);
    #2;
    n_reset = 1'b0;
    #1;
    chk("async_pos",    32'(bus.position), 32'd0);
    chk("async_bottom", 32'(bus.bottom),   32'd0);
    chk("async_moving", 32'(bus.moving),   32'd0);
    tick(1);
    bus.enable = 1'b1;
    n_reset = 1'b1;
    tick(3);
    chk("after_pos", 32'(bus.position), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/lift_shaft_model.md
LIFT_SHAFT_MODEL -- requirements
Module: lift_shaft_model

Interface
REQ-001 Parameter: POS_MAX, default 16, meaning topmost cab position; SHALL be even and at least 4.
REQ-002 Parameter: STEP_CYCLES, default 4, meaning clock cycles per one-position move.
REQ-003 Parameter: RESET_POS, default 0, meaning cab position loaded at reset.
REQ-004 Derived constant: MID = POS_MAX/2; POS_W = clog2(POS_MAX+1).
REQ-005 Ports: clock  in  1  system clock, rising edge.
REQ-006 Ports: n_reset  in  1  asynchronous, active-low reset.
REQ-007 Ports: direction  in  1  motor direction, 1 up, 0 down.
REQ-008 Ports: enable  in  1  motor run, active low.
REQ-009 Ports: bottom  out  1  active low, cab at position 0.
REQ-010 Ports: middle_minus  out  1  active low, position MID-1 or MID.
REQ-011 Ports: middle_plus  out  1  active low, position MID or MID+1.
REQ-012 Ports: top  out  1  active low, position POS_MAX.
REQ-013 Ports: position  out  POS_W  current cab position, unsigned.
REQ-014 Ports: moving  out  1  high in UP or DOWN state.
REQ-015 Ports: overrun  out  1  sticky fault, cab driven past an end stop.

Function
REQ-016 States SHALL be STOPPED, UP, DOWN, FAULT.
REQ-017 STOPPED: enable=0,direction=1 -> UP; enable=0,direction=0 -> DOWN; otherwise hold.
REQ-018 UP/DOWN: enable=1 -> STOPPED with prescaler cleared, position held.
REQ-019 UP with direction=0 (or DOWN with direction=1), enable=0 -> opposite moving state, prescaler cleared, no position change that cycle.
REQ-020 Prescaler counts 0..STEP_CYCLES-1 in UP/DOWN; on terminal count it wraps to 0 and position steps +1 (UP) or -1 (DOWN) on the same edge.
REQ-021 Latency: first edge sampling enable=0 enters UP/DOWN; position changes exactly STEP_CYCLES edges later, then every STEP_CYCLES edges.
REQ-022 Terminal count in UP at position POS_MAX, or DOWN at position 0 -> FAULT; position SHALL NOT wrap or change.
REQ-023 FAULT: overrun=1, position and sensors frozen, inputs ignored; exit only via reset.
REQ-024 Sensors are registered decodes of the next position, so sensors and position change on the same edge; no glitches.
REQ-025 At position MID both middle_minus and middle_plus SHALL be 0; at MID-1 only middle_minus=0; at MID+1 only middle_plus=0.
REQ-026 moving SHALL be 1 in UP/DOWN, 0 in STOPPED/FAULT.

Reset
REQ-027 n_reset=0 SHALL asynchronously force STOPPED, prescaler 0, position RESET_POS, overrun 0, moving 0, sensors decoded from RESET_POS (default: bottom=0, others 1).
REQ-028 Reset asserted mid-move SHALL abandon the move immediately with no partial step.

Structure
REQ-029 Shared package lift_pkg SHALL hold the motion-state enum and default POS_MAX/STEP_CYCLES constants.
REQ-030 Prescaler SHALL be a sub-module step_prescaler (clear, run, terminal-count out).

Verification
REQ-031 Reset at position 0 -> bottom=0, top=middle_minus=middle_plus=1, overrun=0, moving=0.
REQ-032 Defaults, enable=0, direction=1 from 0 -> position 7 after 28 edges (middle_minus=0 only), position 8 after 32 edges (both middle sensors 0).
REQ-033 Moving up, enable=1 at position 5 mid-step -> STOPPED next edge, position stays 5; re-enable -> 6 after 4 more edges.
REQ-034 Direction flipped from 1 to 0 at position 3 -> position 3 held 4 further edges, then 2.
REQ-035 Drive up at position 16 for 4 edges -> overrun=1, top stays 0, position 16; later enable=1 -> still FAULT until reset.
REQ-036 Assert n_reset=0 while at position 9 moving -> immediate position 0, bottom=0, moving=0 without waiting for a clock edge.
